// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchroniser, 11-bit deframer with
// parity/framing/timeout checks, and a small scan-code FIFO.
module ps2_rx_fifo #(
   parameter int FIFO_AW        = 3,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       nextdata_n,
   input  logic       ovf_clr,
   output logic [7:0] data,
   output logic       ready,
   output logic       overflow,
   output logic       frame_err,
   output logic [7:0] err_count
);

   localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
   localparam int DEPTH = 1 << FIFO_AW;

   typedef enum logic {IDLE, RECV} state_t;

   state_t state, state_nx;

   logic clk_s1, clk_s2, clk_h;
   logic dat_s1, dat_s2;
   logic fall;

   logic [3:0]    bitcnt;
   logic [9:0]    sr;
   logic [TW-1:0] tcnt;
   logic          last, good, bad, tmo;

   logic       push_q, err_q;
   logic [7:0] byte_q;

   logic [7:0]     mem [DEPTH];
   logic [FIFO_AW:0] wptr, rptr;
   logic empty, full, pop, wr, ovf_set;

   // Presetting to 1 keeps a reset release from looking like a falling edge
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         clk_h  <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
      end else begin
         clk_s1 <= ps2_clk;
         clk_s2 <= clk_s1;
         clk_h  <= clk_s2;
         dat_s1 <= ps2_data;
         dat_s2 <= dat_s1;
      end
   end

   assign fall = clk_h & ~clk_s2;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) state <= IDLE;
      else       state <= state_nx;
   end

   // sr[0] = start, sr[8:1] = data, sr[9] = parity once bitcnt reaches 10
   always_comb begin
      state_nx = state;
      last     = 1'b0;
      good     = 1'b0;
      bad      = 1'b0;
      tmo      = 1'b0;
      unique case (state)
         IDLE: begin
            if (fall) state_nx = RECV;
         end
         RECV: begin
            if (fall && bitcnt == 4'd10) begin
               last     = 1'b1;
               good     = ~sr[0] & dat_s2 & (^sr[9:1]);
               bad      = ~good;
               state_nx = IDLE;
            end else if (!fall && tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
               tmo      = 1'b1;
               state_nx = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         bitcnt <= '0;
         sr     <= '0;
         tcnt   <= '0;
      end else begin
         if (fall || state == IDLE)
            tcnt <= '0;
         else
            tcnt <= tcnt + {{(TW-1){1'b0}}, 1'b1};
         if (fall) begin
            if (state == IDLE) bitcnt <= 4'd1;
            else if (last)     bitcnt <= 4'd0;
            else               bitcnt <= bitcnt + 4'd1;
            if (!last) sr <= {dat_s2, sr[9:1]};
         end else if (tmo) begin
            bitcnt <= 4'd0;
         end
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         push_q    <= 1'b0;
         byte_q    <= '0;
         err_q     <= 1'b0;
         err_count <= '0;
      end else begin
         push_q <= good;
         err_q  <= bad | tmo;
         if (last) byte_q <= sr[8:1];
         if ((bad | tmo) && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
      end
   end

   assign frame_err = err_q;

   assign empty   = (wptr == rptr);
   assign full    = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                    (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
   assign pop     = ~nextdata_n & ~empty;
   assign wr      = push_q & (~full | pop);
   assign ovf_set = push_q & full & ~pop;

   always_ff @(posedge clk) begin
      if (wr) mem[wptr[FIFO_AW-1:0]] <= byte_q;
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         wptr     <= '0;
         rptr     <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr)  wptr <= wptr + {{FIFO_AW{1'b0}}, 1'b1};
         if (pop) rptr <= rptr + {{FIFO_AW{1'b0}}, 1'b1};
         if (ovf_set)      overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;
      end
   end

   assign ready = ~empty;
   assign data  = empty ? 8'h00 : mem[rptr[FIFO_AW-1:0]];

endmodule
